// File: rtl/trace_capture_ctrl.sv
// Trace RAM sequencer: captures len_m1+1 triggered samples, then dumps them as a valid/ready stream.
// Optional sample decimation is enabled by defining TRACE_CTRL_DECIM_EN.
module trace_capture_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trigger,
  input  logic [ADDR_WIDTH-1:0]   len_m1,
`ifdef TRACE_CTRL_DECIM_EN
  input  logic [7:0]              decim,
`endif
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    dump_start,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ena,
  output logic [DATA_WIDTH/8-1:0] mem_wea,
  output logic [ADDR_WIDTH-1:0]   mem_addra,
  output logic [DATA_WIDTH-1:0]   mem_dina,
  output logic                    mem_enb,
  output logic [ADDR_WIDTH-1:0]   mem_addrb,
  input  logic [DATA_WIDTH-1:0]   mem_doutb
);

  localparam int BW = $clog2(BUF_DEPTH);
  localparam int CW = BW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_DUMP    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cap_ptr;
  logic                  cap_all;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_all;
  logic [RD_LATENCY-1:0] vpipe;
  logic [RD_LATENCY-1:0] lpipe;
  logic [DATA_WIDTH-1:0] buf_dat [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  buf_last;
  logic [CW-1:0]         buf_wp;
  logic [CW-1:0]         buf_rp;

  logic          arm_ok, win, take, issue, push, xfer;
  logic [CW-1:0] buf_count;
  logic [CW:0]   occ;

`ifdef TRACE_CTRL_DECIM_EN
  logic [7:0] decim_q;
  logic [7:0] dcnt;
  assign take = win && (dcnt == 8'd0);
`else
  assign take = win;
`endif

  assign arm_ok = (state == S_IDLE) && arm && !abort;
  // The trigger cycle itself is eligible; cap_all stops intake once the last sample is registered.
  assign win = !abort && s_valid &&
               (((state == S_ARMED) && trigger) || ((state == S_CAPTURE) && !cap_all));

  assign buf_count = buf_wp - buf_rp;
  always_comb begin
    occ = {1'b0, buf_count};
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + (CW+1)'(vpipe[i]);
  end

  assign issue   = (state == S_DUMP) && !abort && !rd_all && (occ < (CW+1)'(BUF_DEPTH));
  assign push    = vpipe[RD_LATENCY-1];
  assign m_valid = (buf_wp != buf_rp);
  assign m_data  = buf_dat[buf_rp[BW-1:0]];
  assign m_last  = m_valid && buf_last[buf_rp[BW-1:0]];
  assign xfer    = m_valid && m_ready;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_ena   = wr_vld;
  assign mem_wea   = {(DATA_WIDTH/8){wr_vld}};
  assign mem_addra = wr_addr;
  assign mem_dina  = wr_dat;
  assign mem_enb   = issue;
  assign mem_addrb = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len_q <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm) begin state <= S_ARMED; len_q <= len_m1; end
        S_ARMED:   if (trigger) state <= S_CAPTURE;
        S_CAPTURE: if (wr_vld && (wr_addr == len_q)) state <= S_DONE;
        S_DONE:    if (dump_start) state <= S_DUMP;
        S_DUMP:    if (xfer && m_last) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ptr <= '0;
      cap_all <= 1'b0;
      wr_vld  <= 1'b0;
      wr_addr <= '0;
      wr_dat  <= '0;
`ifdef TRACE_CTRL_DECIM_EN
      decim_q <= '0;
      dcnt    <= '0;
`endif
    end else begin
      wr_vld <= take;
      if (arm_ok) begin
        cap_ptr <= '0;
        cap_all <= 1'b0;
`ifdef TRACE_CTRL_DECIM_EN
        decim_q <= decim;
        dcnt    <= '0;
`endif
      end
      if (take) begin
        wr_addr <= cap_ptr;
        wr_dat  <= s_data;
        // Saturate on the last address instead of wrapping, so a full-RAM trace ends cleanly.
        if (cap_ptr == len_q) cap_all <= 1'b1;
        else                  cap_ptr <= cap_ptr + 1'b1;
      end
`ifdef TRACE_CTRL_DECIM_EN
      if (win) dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_all   <= 1'b0;
      vpipe    <= '0;
      lpipe    <= '0;
      buf_wp   <= '0;
      buf_rp   <= '0;
      buf_last <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_dat[i] <= '0;
    end else if (abort || (state != S_DUMP)) begin
      // Discard anything in flight; the next dump restarts at address 0.
      rd_ptr <= '0;
      rd_all <= 1'b0;
      vpipe  <= '0;
      lpipe  <= '0;
      buf_wp <= '0;
      buf_rp <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LATENCY'(issue);
      lpipe <= (lpipe << 1) | RD_LATENCY'(issue && (rd_ptr == len_q));
      if (issue) begin
        if (rd_ptr == len_q) rd_all <= 1'b1;
        else                 rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        buf_dat[buf_wp[BW-1:0]]  <= mem_doutb;
        buf_last[buf_wp[BW-1:0]] <= lpipe[RD_LATENCY-1];
        buf_wp <= buf_wp + 1'b1;
      end
      if (xfer) buf_rp <= buf_rp + 1'b1;
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with a behavioural 2-cycle-latency trace RAM.
module tb_trace_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, trigger = 1'b0;
  logic [11:0] len_m1 = '0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        dump_start = 1'b0;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [63:0] m_data;
  logic        busy, done;
  logic        mem_ena, mem_enb;
  logic [7:0]  mem_wea;
  logic [11:0] mem_addra, mem_addrb;
  logic [63:0] mem_dina, mem_doutb;
`ifdef TRACE_CTRL_DECIM_EN
  logic [7:0]  decim = '0;
`endif

  trace_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trigger(trigger),
    .len_m1(len_m1),
`ifdef TRACE_CTRL_DECIM_EN
    .decim(decim),
`endif
    .s_valid(s_valid), .s_data(s_data), .dump_start(dump_start),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_enb(mem_enb),
    .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:4095];
  logic [63:0] rd1, rd2;
  int wr_cnt = 0, iss_cnt = 0, xfer_cnt = 0;
  assign mem_doutb = rd2;

  always @(posedge clk) begin
    if (mem_ena) begin
      for (int b = 0; b < 8; b++)
        if (mem_wea[b]) mem[mem_addra][b*8 +: 8] <= mem_dina[b*8 +: 8];
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_enb) begin
      rd1 <= mem[mem_addrb];
      iss_cnt <= iss_cnt + 1;
    end
    rd2 <= rd1;
    if (m_valid && m_ready) xfer_cnt <= xfer_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic capture(input logic [11:0] len, input logic [63:0] base, input int n,
                         input bit gaps, input int exp_writes);
    int w0;
    w0 = wr_cnt;
    arm = 1'b1; len_m1 = len;
    @(posedge clk); #1 arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      trigger = (i == 0); s_valid = 1'b1; s_data = base + 64'(i);
      @(posedge clk); #1 trigger = 1'b0;
      if (gaps && (i % 3 == 1)) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(posedge clk); #1;
    end
    chk("cap_done", 64'(done), 64'd1);
    chk("cap_writes", 64'(wr_cnt - w0), 64'(exp_writes));
  endtask

  // stop_at > 0 ends the dump after that many words by abort (kill=0) or reset (kill=1).
  task automatic dump(input int n, input logic [63:0] base, input bit rnd,
                      input int stop_at, input bit kill);
    int got, bad, lastbad, first, lastc, cyc, maxo, o0;
    got = 0; bad = 0; lastbad = 0; first = -1; lastc = -1; cyc = 0; maxo = 0;
    o0 = iss_cnt - xfer_cnt;
    dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    while (busy && cyc < 20000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (iss_cnt - xfer_cnt - o0 > maxo) maxo = iss_cnt - xfer_cnt - o0;
      if (m_valid && m_ready) begin
        if (m_data !== base + 64'(got)) bad++;
        if (m_last !== (got == n - 1)) lastbad++;
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (stop_at > 0 && got == stop_at) begin
        m_ready = 1'b0;
        chk("partial_data", 64'(bad), 64'd0);
        if (kill) begin
          rst_n = 1'b0; #1;
          chk("rst_mvalid", 64'(m_valid), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_mem_en", {62'd0, mem_ena, mem_enb}, 64'd0);
          chk("rst_mdata", m_data, 64'd0);
          @(posedge clk); #1 rst_n = 1'b1;
          @(posedge clk); #1;
          chk("post_rst_busy", 64'(busy), 64'd0);
          chk("post_rst_mvalid", 64'(m_valid), 64'd0);
        end else begin
          abort = 1'b1;
          @(posedge clk); #1 abort = 1'b0;
          chk("abort_mvalid", 64'(m_valid), 64'd0);
          chk("abort_busy", 64'(busy), 64'd0);
        end
        return;
      end
    end
    m_ready = 1'b0;
    chk("dump_timeout", 64'(cyc < 20000), 64'd1);
    chk("dump_count", 64'(got), 64'(n));
    chk("dump_data", 64'(bad), 64'd0);
    chk("dump_last", 64'(lastbad), 64'd0);
    chk("dump_outstanding", 64'(maxo <= 4), 64'd1);
    if (!rnd) chk("dump_b2b", 64'(lastc - first), 64'(n - 1));
    @(posedge clk); #1;
    chk("dump_idle", {62'd0, busy, m_valid}, 64'd0);
  endtask

  initial begin
    int w0;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_mvalid", 64'(m_valid), 64'd0);
    chk("reset_mem", {61'd0, done, mem_ena, mem_enb}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // arm and trigger together: trigger is not seen
    w0 = wr_cnt;
    arm = 1'b1; trigger = 1'b1; s_valid = 1'b1; s_data = 64'hFF; len_m1 = 12'd2;
    @(posedge clk); #1 arm = 1'b0; trigger = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk); #1;
    chk("armtrig_busy", 64'(busy), 64'd1);
    chk("armtrig_nowrite", 64'(wr_cnt - w0), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_armed_busy", 64'(busy), 64'd0);

    capture(12'd7, 64'd0, 8, 1'b0, 8);
    chk("ram_word0", mem[0], 64'd0);
    chk("ram_word7", mem[7], 64'd7);
    dump(8, 64'd0, 1'b0, 0, 1'b0);

    capture(12'd7, 64'd0, 8, 1'b1, 8);
    dump(8, 64'd0, 1'b1, 0, 1'b0);

    capture(12'd0, 64'h55, 1, 1'b0, 1);
    dump(1, 64'h55, 1'b0, 0, 1'b0);

    capture(12'd4095, 64'h1000, 4096, 1'b0, 4096);
    dump(4096, 64'h1000, 1'b0, 0, 1'b0);

    capture(12'd7, 64'd0, 8, 1'b0, 8);
    dump(8, 64'd0, 1'b0, 3, 1'b0);
    capture(12'd3, 64'hA, 4, 1'b0, 4);
    dump(4, 64'hA, 1'b1, 0, 1'b0);

`ifdef TRACE_CTRL_DECIM_EN
    decim = 8'd2;
    capture(12'd3, 64'd0, 12, 1'b0, 4);
    chk("decim_w0", mem[0], 64'd0);
    chk("decim_w1", mem[1], 64'd3);
    chk("decim_w2", mem[2], 64'd6);
    chk("decim_w3", mem[3], 64'd9);
    dump(4, 64'd0, 1'b0, 0, 1'b0);
    decim = 8'd0;
`endif

    capture(12'd7, 64'h200, 8, 1'b0, 8);
    dump(8, 64'h200, 1'b0, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
